// File: rtl/lives_pkg.sv
// Shared types and constants for the lives manager: FSM state encoding, life-count width
// and a saturating increment helper.
package lives_pkg;

  localparam int unsigned MAX_LIVES = 3;
  localparam int unsigned LIVES_W   = 2;

  typedef enum logic [1:0] {
    OVER   = 2'd0,
    PLAY   = 2'd1,
    INVULN = 2'd2
  } state_e;

  function automatic logic [LIVES_W-1:0] sat_inc(input logic [LIVES_W-1:0] l);
    return (l == LIVES_W'(MAX_LIVES)) ? l : l + 1'b1;
  endfunction

endpackage

// File: rtl/lives_manager_if.sv
// Pulse inputs and status outputs of the lives manager; master = game logic, slave = manager.
interface lives_manager_if;
  import lives_pkg::*;

  logic               frame_tick;
  logic               hit;
  logic               bonus;
  logic               new_game;
  logic [LIVES_W-1:0] lives;
  logic               game_over;
  logic               invuln;
  logic               blink_hide;
  logic               life_lost;

  modport master (
    output frame_tick, hit, bonus, new_game,
    input  lives, game_over, invuln, blink_hide, life_lost
  );

  modport slave (
    input  frame_tick, hit, bonus, new_game,
    output lives, game_over, invuln, blink_hide, life_lost
  );

endinterface

// File: rtl/lives_manager_invuln_timer.sv
// Loadable frame down-counter for the invulnerability window; flags the final tick and the
// ticks on which the sprite blink phase flips.
module invuln_timer #(
  parameter int INVULN_FRAMES = 120,
  parameter int BLINK_PERIOD  = 8,
  parameter int CNT_W         = $clog2(INVULN_FRAMES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             expire,
  output logic             blink_step
);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] count_m1;

  assign count_m1 = count_q - CNT_W'(1);

  always_comb begin
    count_d = count_q;
    if (clr)
      count_d = '0;
    else if (load)
      count_d = CNT_W'(INVULN_FRAMES);
    else if (en && (count_q != '0))
      count_d = count_m1;
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count      = count_q;
  assign expire     = en && (count_q == CNT_W'(1));
  // BLINK_PERIOD is a power of two, so the modulo reduces to a mask of the low bits
  assign blink_step = en && ((count_m1 & CNT_W'(BLINK_PERIOD - 1)) == '0);

endmodule

// File: rtl/lives_manager.sv
// Player life counter with post-hit invulnerability, sprite blink and game-over flag.
// Define LIVES_EXTRA_LIFE_EN to enable the bonus (extra life) input.
module lives_manager
  import lives_pkg::*;
#(
  parameter int START_LIVES   = 3,
  parameter int INVULN_FRAMES = 120,
  parameter int BLINK_PERIOD  = 8
) (
  input  logic            clk,
  input  logic            rst,
  lives_manager_if.slave  bus
);

  localparam int CNT_W = $clog2(INVULN_FRAMES + 1);

  state_e             state_q, state_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic               game_over_q, game_over_d;
  logic               invuln_q, invuln_d;
  logic               blink_hide_q, blink_hide_d;
  logic               life_lost_q, life_lost_d;

  logic [CNT_W-1:0]   tmr_count;
  logic               tmr_load, tmr_en, tmr_expire, tmr_blink_step;
  logic               bonus_act;

`ifdef LIVES_EXTRA_LIFE_EN
  assign bonus_act = bus.bonus;
`else
  assign bonus_act = 1'b0;
`endif

  invuln_timer #(
    .INVULN_FRAMES (INVULN_FRAMES),
    .BLINK_PERIOD  (BLINK_PERIOD),
    .CNT_W         (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .clr        (bus.new_game),
    .load       (tmr_load),
    .en         (tmr_en),
    .count      (tmr_count),
    .expire     (tmr_expire),
    .blink_step (tmr_blink_step)
  );

  always_comb begin
    state_d      = state_q;
    lives_d      = lives_q;
    game_over_d  = game_over_q;
    invuln_d     = invuln_q;
    blink_hide_d = blink_hide_q;
    life_lost_d  = 1'b0;
    tmr_load     = 1'b0;
    tmr_en       = 1'b0;
    if (bus.new_game) begin
      state_d      = PLAY;
      lives_d      = LIVES_W'(START_LIVES);
      game_over_d  = 1'b0;
      invuln_d     = 1'b0;
      blink_hide_d = 1'b0;
    end else begin
      unique case (state_q)
        PLAY: begin
          if (bus.hit) begin
            life_lost_d = 1'b1;
            // a simultaneous bonus cancels the life loss, so the hit is never fatal then
            if (bonus_act || (lives_q > LIVES_W'(1))) begin
              if (!bonus_act) lives_d = lives_q - 1'b1;
              state_d      = INVULN;
              invuln_d     = 1'b1;
              blink_hide_d = 1'b1;
              tmr_load     = 1'b1;
            end else begin
              lives_d     = '0;
              state_d     = OVER;
              game_over_d = 1'b1;
            end
          end else if (bonus_act) begin
            lives_d = sat_inc(lives_q);
          end
        end
        INVULN: begin
          if (bonus_act) lives_d = sat_inc(lives_q);
          tmr_en = bus.frame_tick && (tmr_count != '0);
          if (tmr_expire) begin
            state_d      = PLAY;
            invuln_d     = 1'b0;
            blink_hide_d = 1'b0;
          end else if (tmr_blink_step) begin
            blink_hide_d = ~blink_hide_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= OVER;
      lives_q      <= '0;
      game_over_q  <= 1'b1;
      invuln_q     <= 1'b0;
      blink_hide_q <= 1'b0;
      life_lost_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      lives_q      <= lives_d;
      game_over_q  <= game_over_d;
      invuln_q     <= invuln_d;
      blink_hide_q <= blink_hide_d;
      life_lost_q  <= life_lost_d;
    end
  end

  assign bus.lives      = lives_q;
  assign bus.game_over  = game_over_q;
  assign bus.invuln     = invuln_q;
  assign bus.blink_hide = blink_hide_q;
  assign bus.life_lost  = life_lost_q;

endmodule

// File: tb/tb_lives_manager.sv
// Self-checking bench for lives_manager: directed scenarios plus randomized pulses checked
// against a behavioural model that tracks frames elapsed since the last accepted hit.
module tb_lives_manager;

  localparam int START = 3;
  localparam int FR    = 120;
  localparam int BP    = 8;
`ifdef LIVES_EXTRA_LIFE_EN
  localparam bit BON = 1'b1;
`else
  localparam bit BON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lives_manager_if bus();

  lives_manager #(
    .START_LIVES   (START),
    .INVULN_FRAMES (FR),
    .BLINK_PERIOD  (BP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // behavioural model
  int m_lives   = 0;
  bit m_playing = 1'b0;
  bit m_inv     = 1'b0;
  bit m_lost    = 1'b0;
  int m_elapsed = 0;

  // sprite starts hidden and flips on every tick whose pre-tick timer T has (T-1)%BP==0,
  // i.e. tick number j with j%BP == FR%BP
  function automatic bit m_hide();
    int flips = 0;
    if (!m_inv) return 1'b0;
    for (int j = 1; j <= m_elapsed; j++)
      if ((j % BP) == (FR % BP)) flips++;
    return (flips % 2) == 0;
  endfunction

  task automatic model_step(input bit r, input bit ng, input bit h, input bit b, input bit t);
    m_lost = 1'b0;
    if (r) begin
      m_lives = 0; m_playing = 1'b0; m_inv = 1'b0; m_elapsed = 0;
    end else if (ng) begin
      m_lives = START; m_playing = 1'b1; m_inv = 1'b0; m_elapsed = 0;
    end else if (m_playing && !m_inv) begin
      if (h) begin
        m_lost = 1'b1;
        if (BON && b) begin
          m_inv = 1'b1; m_elapsed = 0;
        end else if (m_lives > 1) begin
          m_lives--; m_inv = 1'b1; m_elapsed = 0;
        end else begin
          m_lives = 0; m_playing = 1'b0;
        end
      end else if (BON && b && m_lives < 3) begin
        m_lives++;
      end
    end else if (m_playing) begin
      if (BON && b && m_lives < 3) m_lives++;
      if (t) begin
        m_elapsed++;
        if (m_elapsed == FR) m_inv = 1'b0;
      end
    end
  endtask

  task automatic step(input bit r, input bit ng, input bit h, input bit b, input bit t);
    rst = r; bus.new_game = ng; bus.hit = h; bus.bonus = b; bus.frame_tick = t;
    @(posedge clk);
    model_step(r, ng, h, b, t);
    @(negedge clk);
    rst = 1'b0; bus.new_game = 1'b0; bus.hit = 1'b0; bus.bonus = 1'b0; bus.frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1);
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0);
    n_cmp++;
    if (bus.lives !== 2'd0) begin n_bad++; $display("FAIL reset_lives: got %0d expected 0", bus.lives); end
    n_cmp++;
    if ({bus.game_over, bus.invuln, bus.blink_hide, bus.life_lost} !== 4'b1000) begin
      n_bad++; $display("FAIL reset_flags: got %b expected 1000",
                        {bus.game_over, bus.invuln, bus.blink_hide, bus.life_lost});
    end
    step(0, 0, 1, 0, 1);
    n_cmp++;
    if ({bus.lives, bus.life_lost, bus.game_over} !== 4'b0001) begin
      n_bad++; $display("FAIL over_hit_ignored: got %b expected 0001",
                        {bus.lives, bus.life_lost, bus.game_over});
    end
  endtask

  task automatic test_new_game();
    step(0, 1, 0, 0, 0);
    n_cmp++;
    if (bus.lives !== 2'd3) begin n_bad++; $display("FAIL ng_lives: got %0d expected 3", bus.lives); end
    n_cmp++;
    if ({bus.game_over, bus.invuln} !== 2'b00) begin
      n_bad++; $display("FAIL ng_flags: got %b expected 00", {bus.game_over, bus.invuln});
    end
  endtask

  task automatic test_hit_invuln();
    step(0, 0, 1, 0, 0);
    n_cmp++;
    if ({bus.lives, bus.life_lost, bus.invuln, bus.blink_hide} !== 5'b10111) begin
      n_bad++; $display("FAIL hit_enter: got %b expected 10111",
                        {bus.lives, bus.life_lost, bus.invuln, bus.blink_hide});
    end
    for (int i = 1; i <= FR; i++) begin
      step(0, 0, (i % 10) == 3, 0, 1);
      if (i < FR) begin
        n_cmp++;
        if ({bus.lives, bus.invuln, bus.life_lost} !== 4'b1010) begin
          n_bad++; $display("FAIL invuln_hold t%0d: got %b expected 1010", i,
                            {bus.lives, bus.invuln, bus.life_lost});
        end
        n_cmp++;
        if (bus.blink_hide !== m_hide()) begin
          n_bad++; $display("FAIL blink t%0d: got %b expected %b", i, bus.blink_hide, m_hide());
        end
      end
      if (i == 7 || i == 8 || i == 16) begin
        n_cmp++;
        if (bus.blink_hide !== (i == 7 || i == 16)) begin
          n_bad++; $display("FAIL blink_edge t%0d: got %b expected %b", i, bus.blink_hide, i != 8);
        end
      end
    end
    n_cmp++;
    if ({bus.invuln, bus.blink_hide, bus.lives} !== 4'b0010) begin
      n_bad++; $display("FAIL invuln_exit: got %b expected 0010",
                        {bus.invuln, bus.blink_hide, bus.lives});
    end
  endtask

  task automatic test_game_over();
    step(0, 1, 0, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      step(0, 0, 1, 0, 1);
      n_cmp++;
      if ({bus.lives, bus.life_lost} !== {2'(3 - k), 1'b1}) begin
        n_bad++; $display("FAIL go_hit%0d: got %b expected %b", k,
                          {bus.lives, bus.life_lost}, {2'(3 - k), 1'b1});
      end
      if (k < 3) ticks(FR);
    end
    n_cmp++;
    if ({bus.game_over, bus.invuln} !== 2'b10) begin
      n_bad++; $display("FAIL go_flag: got %b expected 10", {bus.game_over, bus.invuln});
    end
    step(0, 0, 1, 0, 0);
    n_cmp++;
    if ({bus.lives, bus.life_lost, bus.game_over} !== 4'b0001) begin
      n_bad++; $display("FAIL go_hit_after: got %b expected 0001",
                        {bus.lives, bus.life_lost, bus.game_over});
    end
  endtask

  task automatic test_ng_priority();
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    ticks(5);
    step(0, 1, 1, 1, 1);
    n_cmp++;
    if ({bus.lives, bus.invuln, bus.game_over, bus.life_lost, bus.blink_hide} !== 6'b110000) begin
      n_bad++; $display("FAIL ng_hit: got %b expected 110000",
                        {bus.lives, bus.invuln, bus.game_over, bus.life_lost, bus.blink_hide});
    end
    step(0, 0, 1, 0, 0);
    n_cmp++;
    if ({bus.lives, bus.life_lost, bus.invuln} !== 4'b1011) begin
      n_bad++; $display("FAIL ng_then_play: got %b expected 1011",
                        {bus.lives, bus.life_lost, bus.invuln});
    end
  endtask

  task automatic test_bonus();
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    n_cmp++;
    if (bus.lives !== 2'd3) begin n_bad++; $display("FAIL bonus_sat: got %0d expected 3", bus.lives); end
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    n_cmp++;
    if (bus.lives !== (BON ? 2'd3 : 2'd2)) begin
      n_bad++; $display("FAIL bonus_inc: got %0d expected %0d", bus.lives, BON ? 3 : 2);
    end
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    ticks(FR);
    step(0, 0, 1, 0, 0);
    ticks(FR);
    step(0, 0, 1, 1, 0);
    n_cmp++;
    if ({bus.lives, bus.invuln, bus.game_over, bus.life_lost} !==
        (BON ? 5'b01101 : 5'b00011)) begin
      n_bad++; $display("FAIL hit_bonus_last: got %b expected %b",
                        {bus.lives, bus.invuln, bus.game_over, bus.life_lost},
                        BON ? 5'b01101 : 5'b00011);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 6000; i++) begin
      step(($urandom % 700) == 0, ($urandom % 150) == 0, ($urandom % 15) == 0,
           ($urandom % 25) == 0, ($urandom % 2) == 0);
      n_cmp++;
      if (bus.lives !== 2'(m_lives)) begin
        n_bad++; $display("FAIL rnd_lives c%0d: got %0d expected %0d", i, bus.lives, m_lives);
      end
      n_cmp++;
      if ({bus.game_over, bus.invuln, bus.blink_hide, bus.life_lost} !==
          {!m_playing, m_inv, m_hide(), m_lost}) begin
        n_bad++; $display("FAIL rnd_flags c%0d: got %b expected %b", i,
                          {bus.game_over, bus.invuln, bus.blink_hide, bus.life_lost},
                          {!m_playing, m_inv, m_hide(), m_lost});
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.new_game = 1'b0; bus.hit = 1'b0; bus.bonus = 1'b0; bus.frame_tick = 1'b0;
    @(negedge clk);
    test_reset();
    test_new_game();
    test_hit_invuln();
    test_game_over();
    test_ng_priority();
    test_bonus();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
